// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud-timing helpers
// used by both the receiver and the transmitter rework.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_t;

    // Lowest clock-to-baud ratio at which centre sampling still has margin.
    localparam int MIN_RATIO = 16;

    // Last counter value of a full bit period.
    function automatic int bit_max(input int clk_hz, input int baud);
        return clk_hz / baud - 1;
    endfunction

    // Last counter value of half a bit period (start-bit centre).
    function automatic int half_max(input int clk_hz, input int baud);
        return (clk_hz / baud) / 2 - 1;
    endfunction

endpackage

// File: rtl/sync_vote3.sv
// Input conditioning for the serial pin: 2-flop synchronizer, 3-sample
// history, majority vote and falling-edge detect on the synchronized line.
module sync_vote3 (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic line,
    output logic vote,
    output logic fall
);

    logic       sync1;
    logic       sync2;
    logic [2:0] hist;

    // Synchronize the pin and keep the last three synchronized samples.
    always_ff @(posedge clk) begin
        // NOTE: every flop resets to 1 (idle line) so leaving reset can never look like a start edge.
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            hist  <= 3'b111;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            hist  <= {hist[1:0], sync2};
        end
    end

    assign line = sync2;
    assign vote = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
    // hist[0] is the synchronized value one cycle earlier.
    assign fall = ~sync2 & hist[0];

endmodule

// File: rtl/uart_rx_v2.sv
// 8N1 UART receiver, LSB first. One majority vote per bit at the bit centre;
// each good byte is presented with a one-cycle rx_valid strobe.
module uart_rx_v2
    import uart_pkg::*;
#(
    parameter int clk_freq  = 12000000,
    parameter int uart_freq = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_p,
    output logic [7:0] dout,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int BIT_MAX  = bit_max(clk_freq, uart_freq);
    localparam int HALF_MAX = half_max(clk_freq, uart_freq);
    localparam int CW       = $clog2(BIT_MAX + 1);

    localparam logic [CW-1:0] BIT_LIM  = CW'(BIT_MAX);
    localparam logic [CW-1:0] HALF_LIM = CW'(HALF_MAX);

    // Refuse to elaborate with too few clocks per bit.
    generate
        if (clk_freq / uart_freq < MIN_RATIO) begin : g_ratio_check
            $error("uart_rx_v2: clk_freq/uart_freq must be at least 16");
        end
    endgenerate

    uart_state_t state, state_nxt;
    logic [CW-1:0] cnt;
    logic          cnt_clr;
    logic [2:0]    bitpos, bitpos_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic [7:0]    dout_nxt;
    logic          valid_nxt;
    logic          ferr_nxt;

    logic line;
    logic vote;
    logic fall;

    sync_vote3 u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (rx_p),
        .line  (line),
        .vote  (vote),
        .fall  (fall)
    );

    // Next-state, shift-register and output decisions at each sample point.
    always_comb begin
        // NOTE: every variable gets a default first, so no path through the case can infer a latch.
        state_nxt  = state;
        bitpos_nxt = bitpos;
        shreg_nxt  = shreg;
        dout_nxt   = dout;
        valid_nxt  = 1'b0;
        ferr_nxt   = 1'b0;
        cnt_clr    = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (fall) begin
                    state_nxt = ST_START;
                    cnt_clr   = 1'b1;
                end
            end
            ST_START: begin
                if (cnt == HALF_LIM) begin
                    cnt_clr = 1'b1;
                    if (!vote) begin
                        state_nxt  = ST_DATA;
                        bitpos_nxt = 3'd0;
                    end else begin
                        // Line was back high at the start-bit centre: glitch.
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (cnt == BIT_LIM) begin
                    cnt_clr           = 1'b1;
                    shreg_nxt[bitpos] = vote;
                    if (bitpos == 3'd7) begin
                        state_nxt = ST_STOP;
                    end else begin
                        bitpos_nxt = bitpos + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (cnt == BIT_LIM) begin
                    cnt_clr = 1'b1;
                    if (vote) begin
                        dout_nxt  = shreg;
                        valid_nxt = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                // Hold off until the line idles so a stuck-low pin cannot retrigger.
                if (line) begin
                    state_nxt = ST_IDLE;
                    cnt_clr   = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_clr   = 1'b1;
            end
        endcase
    end

    // State, counter, data path and output registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bitpos    <= 3'd0;
            shreg     <= 8'h00;
            dout      <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            bitpos    <= bitpos_nxt;
            shreg     <= shreg_nxt;
            dout      <= dout_nxt;
            rx_valid  <= valid_nxt;
            frame_err <= ferr_nxt;
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt != BIT_LIM) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign rx_busy = (state != ST_IDLE);

endmodule
